// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter.
package fifo_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    BURST = ST_BURST,
    STALL = ST_STALL
  } arb_state_t;

  // Index width that stays legal (>=1) for degenerate counts.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin pick: first set bit of req scanning from last_idx+1, wrapping modulo N.
module rr_select
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_idx,
  output logic [IW-1:0] next_idx,
  output logic          found
);

  logic [31:0]   sum;
  logic [IW-1:0] idx;

  always_comb begin
    next_idx = last_idx;
    found    = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      sum = 32'(last_idx) + k;
      idx = IW'(sum % N);
      if (!found && req[idx]) begin
        found    = 1'b1;
        next_idx = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-mode write arbiter feeding one FIFO from NUM_REQ requesters.
// Define FIFO_ARB_PRIORITY_EN to let requester 0 win every arbitration it contends.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = 4,
  parameter  int unsigned FIFO_WIDTH = 8,
  parameter  int unsigned FIFO_DEPTH = 8,
  parameter  int unsigned MAX_BURST  = 4,
  localparam int unsigned GW         = idx_width(NUM_REQ),
  localparam int unsigned CW         = $clog2(FIFO_DEPTH) + 1,
  localparam int unsigned BW         = idx_width(MAX_BURST)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            reqValid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] reqData,
  output logic [NUM_REQ-1:0]            reqReady,
  input  logic [CW-1:0]                 fifoDataCount,
  output logic                          fifoWrEn,
  output logic [FIFO_WIDTH-1:0]         fifoWrData,
  output logic [GW-1:0]                 grantId,
  output logic                          arbBusy
);

  arb_state_t            state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [BW-1:0]         burst_cnt_q, burst_cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic [FIFO_WIDTH-1:0] wr_data_q, wr_data_d;

  logic [CW:0]           occupancy;
  logic                  space_ok;
  logic [NUM_REQ-1:0]    arb_req;
  logic [GW-1:0]         rr_idx, pick_idx;
  logic                  rr_found, pick_ok;
  logic                  grant_valid;
  logic [FIFO_WIDTH-1:0] grant_data;

  // One extra bit so a full count plus a pending write cannot wrap.
  assign occupancy = {1'b0, fifoDataCount} + {{CW{1'b0}}, wr_en_q};
  assign space_ok  = occupancy < (CW+1)'(FIFO_DEPTH);

  rr_select #(.N(NUM_REQ)) u_rr_select (
    .req      (arb_req),
    .last_idx (grant_q),
    .next_idx (rr_idx),
    .found    (rr_found)
  );

`ifdef FIFO_ARB_PRIORITY_EN
  assign arb_req  = {reqValid[NUM_REQ-1:1], 1'b0};
  assign pick_idx = reqValid[0] ? '0 : rr_idx;
  assign pick_ok  = reqValid[0] | rr_found;
`else
  assign arb_req  = reqValid;
  assign pick_idx = rr_idx;
  assign pick_ok  = rr_found;
`endif

  assign grant_valid = reqValid[grant_q];
  assign grant_data  = reqData[grant_q*FIFO_WIDTH +: FIFO_WIDTH];

  // Masked during reset so nothing is accepted on an edge that aborts the burst.
  always_comb begin
    reqReady = '0;
    if (state_q == BURST && !reset) reqReady[grant_q] = space_ok;
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    burst_cnt_d = burst_cnt_q;
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data_q;
    unique case (state_q)
      IDLE: begin
        if (pick_ok) begin
          grant_d     = pick_idx;
          burst_cnt_d = '0;
          state_d     = BURST;
        end
      end
      BURST: begin
        if (!grant_valid) begin
          state_d = IDLE;
        end else if (!space_ok) begin
          state_d = STALL;
        end else begin
          wr_en_d     = 1'b1;
          wr_data_d   = grant_data;
          burst_cnt_d = burst_cnt_q + 1'b1;
          if (burst_cnt_q == BW'(MAX_BURST - 1)) state_d = IDLE;
        end
      end
      STALL: begin
        if (space_ok) state_d = BURST;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= GW'(NUM_REQ - 1);
      burst_cnt_q <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign fifoWrEn   = wr_en_q;
  assign fifoWrData = wr_data_q;
  assign grantId    = grant_q;
  assign arbBusy    = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter with a cycle-level behavioural reference model.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int DEPTH = 8;
  localparam int MAXB  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  reqValid = '0;
  logic [31:0] reqData = '0;
  logic [3:0]  reqReady;
  logic [3:0]  fifoDataCount = '0;
  logic        fifoWrEn;
  logic [7:0]  fifoWrData;
  logic [1:0]  grantId;
  logic        arbBusy;

  fifo_wr_arbiter #(.NUM_REQ(NREQ), .FIFO_WIDTH(8), .FIFO_DEPTH(DEPTH), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset), .reqValid(reqValid), .reqData(reqData), .reqReady(reqReady),
    .fifoDataCount(fifoDataCount), .fifoWrEn(fifoWrEn), .fifoWrData(fifoWrData),
    .grantId(grantId), .arbBusy(arbBusy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] data; logic [1:0] gid; } wr_t;
  wr_t exp_q[$];

  int checks = 0;
  int passes = 0;

  // Reference model state: who holds the grant, how many words it has moved, whether waiting on space.
  bit         m_active = 0;
  bit         m_stall = 0;
  int         m_g = NREQ - 1;
  int         m_done = 0;
  bit         m_wr_prev = 0;
  logic [7:0] hold_data = '0;
  bit         rst_prev = 0;

  int dut_grants[$];
  int dut_runs[$];
  int dut_data[$];
  bit mon_prev_wr = 0;
  int mon_run = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic int pick_next(input logic [3:0] v, input int last);
`ifdef FIFO_ARB_PRIORITY_EN
    if (v[0]) return 0;
`endif
    for (int k = 1; k <= NREQ; k++) begin
      automatic int c = (last + k) % NREQ;
`ifdef FIFO_ARB_PRIORITY_EN
      if (c == 0) continue;
`endif
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_step();
    logic [3:0] er;
    bit space, next_wr;
    int p;
    er = '0;
    next_wr = 0;
    space = (int'(fifoDataCount) + (m_wr_prev ? 1 : 0)) < DEPTH;
    if (reset) begin
      chk("reqReady in reset", reqReady, 4'b0000);
      m_active = 0; m_stall = 0; m_g = NREQ - 1; m_done = 0; m_wr_prev = 0;
      hold_data = '0;
      exp_q.delete();
      return;
    end
    if (m_active && !m_stall) er[m_g] = space;
    chk("reqReady", reqReady, er);
    chk("arbBusy", arbBusy, m_active);
    chk("grantId", grantId, m_g);
    if (!m_active) begin
      p = pick_next(reqValid, m_g);
      if (p >= 0) begin m_active = 1; m_g = p; m_done = 0; m_stall = 0; end
    end else if (m_stall) begin
      if (space) m_stall = 0;
    end else if (!reqValid[m_g]) begin
      m_active = 0;
    end else if (!space) begin
      m_stall = 1;
    end else begin
      exp_q.push_back('{data: reqData[m_g*8 +: 8], gid: 2'(m_g)});
      m_done++;
      next_wr = 1;
      if (m_done == MAXB) m_active = 0;
    end
    m_wr_prev = next_wr;
  endtask

  task automatic cycle(input logic rst, input logic [3:0] v, input logic [31:0] d, input logic [3:0] cnt);
    @(posedge clk);
    #1;
    if (rst_prev) begin
      chk("reset fifoWrEn", fifoWrEn, 1'b0);
      chk("reset fifoWrData", fifoWrData, 8'h00);
      chk("reset grantId", grantId, 2'd3);
      chk("reset arbBusy", arbBusy, 1'b0);
    end
    reset = rst; reqValid = v; reqData = d; fifoDataCount = cnt;
    #3;
    model_step();
    rst_prev = rst;
  endtask

  task automatic clear_logs();
    dut_grants.delete(); dut_runs.delete(); dut_data.delete();
  endtask

  task automatic do_reset();
    cycle(1'b1, 4'b0000, 32'h0, 4'd0);
    cycle(1'b1, 4'b0000, 32'h0, 4'd0);
  endtask

  // Monitor: pops the scoreboard on every write and logs burst starts/lengths.
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #2;
      if (fifoWrEn === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected write: got data %0h grant %0d, expected no write (t=%0t)", fifoWrData, grantId, $time);
        end else begin
          e = exp_q.pop_front();
          chk("fifoWrData", fifoWrData, e.data);
          chk("write grantId", grantId, e.gid);
          hold_data = e.data;
        end
        dut_data.push_back(int'(fifoWrData));
        if (!mon_prev_wr) begin dut_grants.push_back(int'(grantId)); mon_run = 1; end
        else mon_run++;
      end else begin
        chk("fifoWrEn idle", fifoWrEn, 1'b0);
        chk("fifoWrData hold", fifoWrData, hold_data);
        if (mon_prev_wr) dut_runs.push_back(mon_run);
      end
      mon_prev_wr = (fifoWrEn === 1'b1);
    end
  end

  initial begin
    logic [7:0] seq_a [5];
    int exp_b [5];
    int exp_e [4];
    logic [3:0] v;
    logic       r;
    seq_a = '{8'hA1, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    exp_b = '{0, 1, 2, 3, 0};
`ifdef FIFO_ARB_PRIORITY_EN
    exp_e = '{0, 0, 0, 0};
`else
    exp_e = '{0, 1, 3, 0};
`endif

    do_reset();

    // Single requester, data A1..A4.
    clear_logs();
    for (int i = 0; i < 5; i++) cycle(1'b0, 4'b0001, {24'h0, seq_a[i]}, 4'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0000, 32'h0, 4'd0);
    for (int i = 0; i < 4; i++) chk($sformatf("single data[%0d]", i), 64'(q_at(dut_data, i)), 64'(32'hA1 + i));
    chk("single grant", 64'(q_at(dut_grants, 0)), 64'd0);
    chk("single burst len", 64'(q_at(dut_runs, 0)), 64'd4);
    chk("single write count", 64'(dut_data.size()), 64'd4);

    // All requesters held: full-length bursts in rotation.
    do_reset();
    clear_logs();
    for (int i = 0; i < 25; i++) cycle(1'b0, 4'b1111, $urandom, 4'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0000, 32'h0, 4'd0);
    for (int i = 0; i < 5; i++) chk($sformatf("rr grant[%0d]", i), 64'(q_at(dut_grants, i)), 64'(exp_b[i]));
    for (int i = 0; i < 4; i++) chk($sformatf("rr burst len[%0d]", i), 64'(q_at(dut_runs, i)), 64'd4);

    // Nearly full FIFO: stall then resume.
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b0, 4'b0001, $urandom, 4'd7);
    for (int i = 0; i < 4; i++) cycle(1'b0, 4'b0001, $urandom, 4'd6);
    for (int i = 0; i < 8; i++) cycle(1'b0, 4'b0001, $urandom, 4'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0000, 32'h0, 4'd8);

    // Reset on the second cycle of a burst.
    do_reset();
    cycle(1'b0, 4'b1111, $urandom, 4'd0);
    cycle(1'b0, 4'b1111, $urandom, 4'd0);
    cycle(1'b1, 4'b1111, $urandom, 4'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0000, 32'h0, 4'd0);

    // Requesters 0, 1, 3 held.
    do_reset();
    clear_logs();
    for (int i = 0; i < 22; i++) cycle(1'b0, 4'b1011, $urandom, 4'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0000, 32'h0, 4'd0);
    for (int i = 0; i < 4; i++) chk($sformatf("1011 grant[%0d]", i), 64'(q_at(dut_grants, i)), 64'(exp_e[i]));

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      for (int b = 0; b < 4; b++) v[b] = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 199) == 0);
      cycle(r, v, $urandom, 4'($urandom_range(0, DEPTH)));
    end

    for (int i = 0; i < 4; i++) cycle(1'b0, 4'b0000, 32'h0, 4'd0);
    chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
